// File: rtl/clock_ctrl.sv
// Sequencer for the time counter bank: builds the run-mode carry chain from the 1 Hz tick,
// drives days-in-month / hour maximum, and provides a button-driven field set mode.
module clock_ctrl #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] day,
  input  logic [3:0] month,
  input  logic [6:0] year,
  input  logic [4:0] done_inc,
  input  logic [4:0] done_dec,
  output logic [5:0] inc,
  output logic [5:0] dec,
  output logic [5:0] en,
  output logic [4:0] day_num,
  output logic [4:0] hour_num,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StSetSec   = 3'd1,
    StSetMin   = 3'd2,
    StSetHour  = 3'd3,
    StSetDay   = 3'd4,
    StSetMonth = 3'd5,
    StSetYear  = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] inc_q, inc_d;
  logic [5:0] dec_q, dec_d;
  logic [5:0] en_q, en_d;
  logic       toggle_q, toggle_d;
  logic       clamp;
  logic [5:0] sel;

  // Borrows are never propagated and only the leap bits of the year matter.
  logic unused_bits;
  assign unused_bits = ^{done_dec, year[6:2]};

  // All fields enabled in run mode, otherwise the one field being edited.
  function automatic logic [5:0] field_oh(state_e s);
    if (s == StRun) return 6'b111111;
    return 6'b000001 << (s - 3'd1);
  endfunction

  always_comb begin
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: day_num = 5'd30;
      4'd2:                    day_num = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 day_num = 5'd31;
    endcase
  end

  assign hour_num = 5'(HOUR_MAX);

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      unique case (state_q)
        StRun:      state_d = StSetSec;
        StSetSec:   state_d = StSetMin;
        StSetMin:   state_d = StSetHour;
        StSetHour:  state_d = StSetDay;
        StSetDay:   state_d = StSetMonth;
        StSetMonth: state_d = StSetYear;
        StSetYear:  state_d = StRun;
        default:    state_d = StRun;
      endcase
    end
  end

  always_comb begin
    inc_d = '0;
    dec_d = '0;
    sel   = field_oh(state_q);
    if (state_q == StRun) begin
      inc_d = {done_inc, tick};
    end else if (!btn_mode && (btn_up ^ btn_down)) begin
      if (btn_up) inc_d = sel;
      else        dec_d = sel;
    end
    // Only a run-mode day carry blocks the clamp; in SET_DAY the clamp wins over buttons.
    // The toggle leaves a gap cycle so the day counter can settle before re-checking.
    clamp    = (day > day_num) && !toggle_q && !((state_q == StRun) && done_inc[2]);
    toggle_d = clamp;
    en_d     = field_oh(state_d);
    if (clamp) begin
      inc_d[3] = 1'b0;
      dec_d[3] = 1'b1;
      en_d[3]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      inc_q    <= '0;
      dec_q    <= '0;
      en_q     <= '0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      en_q     <= en_d;
      toggle_q <= toggle_d;
    end
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign en   = en_q;
  assign mode = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: behavioural counter bank plus a queue-based scoreboard; the monitor
// compares every inc/dec pulse and every queued signal check.
module tb_clock_ctrl;

  logic       clk;
  logic       reset;
  logic       tick, btn_mode, btn_up, btn_down;
  logic [4:0] done_dec;
  logic [5:0] inc, dec, en;
  logic [4:0] day_num, hour_num;
  logic [2:0] mode;

  // Counter bank model
  logic [5:0] m_sec = '0, m_min = '0;
  logic [4:0] m_hour = '0, m_day = 5'd1;
  logic [3:0] m_month = 4'd1;
  logic [6:0] m_year = '0;
  logic [4:0] m_done = '0;

  logic       ld;
  logic [5:0] ld_sec, ld_min;
  logic [4:0] ld_hour, ld_day;
  logic [3:0] ld_month;
  logic [6:0] ld_year;

  clock_ctrl #(.HOUR_MAX(23)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .day      (m_day),
    .month    (m_month),
    .year     (m_year),
    .done_inc (m_done),
    .done_dec (done_dec),
    .inc      (inc),
    .dec      (dec),
    .en       (en),
    .day_num  (day_num),
    .hour_num (hour_num),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_done <= '0;
    if (ld) begin
      m_sec <= ld_sec; m_min <= ld_min; m_hour <= ld_hour;
      m_day <= ld_day; m_month <= ld_month; m_year <= ld_year;
    end else begin
      if (en[0] && inc[0]) begin
        if (m_sec >= 6'd59) begin m_sec <= '0; m_done[0] <= 1'b1; end
        else m_sec <= m_sec + 6'd1;
      end else if (en[0] && dec[0]) m_sec <= (m_sec == 6'd0) ? 6'd59 : m_sec - 6'd1;
      if (en[1] && inc[1]) begin
        if (m_min >= 6'd59) begin m_min <= '0; m_done[1] <= 1'b1; end
        else m_min <= m_min + 6'd1;
      end else if (en[1] && dec[1]) m_min <= (m_min == 6'd0) ? 6'd59 : m_min - 6'd1;
      if (en[2] && inc[2]) begin
        if (m_hour >= hour_num) begin m_hour <= '0; m_done[2] <= 1'b1; end
        else m_hour <= m_hour + 5'd1;
      end else if (en[2] && dec[2]) m_hour <= (m_hour == 5'd0) ? hour_num : m_hour - 5'd1;
      if (en[3] && inc[3]) begin
        if (m_day >= day_num) begin m_day <= 5'd1; m_done[3] <= 1'b1; end
        else m_day <= m_day + 5'd1;
      end else if (en[3] && dec[3]) m_day <= (m_day <= 5'd1) ? day_num : m_day - 5'd1;
      if (en[4] && inc[4]) begin
        if (m_month >= 4'd12) begin m_month <= 4'd1; m_done[4] <= 1'b1; end
        else m_month <= m_month + 4'd1;
      end else if (en[4] && dec[4]) m_month <= (m_month <= 4'd1) ? 4'd12 : m_month - 4'd1;
      if (en[5] && inc[5]) m_year <= (m_year >= 7'd99) ? 7'd0 : m_year + 7'd1;
      else if (en[5] && dec[5]) m_year <= (m_year == 7'd0) ? 7'd99 : m_year - 7'd1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [5:0] inc;
    logic [5:0] dec;
    logic [5:0] en;
    logic [2:0] mode;
  } ev_t;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  localparam int S_INC = 0, S_DEC = 1, S_EN = 2, S_MODE = 3, S_DNUM = 4, S_HNUM = 5;
  localparam int S_SEC = 6, S_MIN = 7, S_HOUR = 8, S_DAY = 9, S_MONTH = 10, S_YEAR = 11;
  localparam int S_DONE0 = 12;

  ev_t  ev_q[$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic finishing = 1'b0;

  function automatic logic [31:0] pick(int s);
    case (s)
      S_INC:   return 32'(inc);
      S_DEC:   return 32'(dec);
      S_EN:    return 32'(en);
      S_MODE:  return 32'(mode);
      S_DNUM:  return 32'(day_num);
      S_HNUM:  return 32'(hour_num);
      S_SEC:   return 32'(m_sec);
      S_MIN:   return 32'(m_min);
      S_HOUR:  return 32'(m_hour);
      S_DAY:   return 32'(m_day);
      S_MONTH: return 32'(m_month);
      S_YEAR:  return 32'(m_year);
      S_DONE0: return 32'(m_done[0]);
      default: return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t        c;
    ev_t         e;
    logic [31:0] act;
    #1;
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = pick(c.sel);
      n_cmp++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: actual %0d, required %0d", c.name, act, c.exp);
      end
    end
    if (!reset && (inc != 6'd0 || dec != 6'd0)) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: actual inc=%b dec=%b mode=%0d, required no pulse",
                 inc, dec, mode);
      end else begin
        e = ev_q.pop_front();
        if ({inc, dec, en, mode} !== {e.inc, e.dec, e.en, e.mode}) begin
          n_fail++;
          $display("FAIL pulse: actual inc=%b dec=%b en=%b mode=%0d, required inc=%b dec=%b en=%b mode=%0d",
                   inc, dec, en, mode, e.inc, e.dec, e.en, e.mode);
        end
      end
    end
    if (finishing) begin
      n_cmp++;
      if (ev_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_pulses: actual %0d pulses outstanding, required 0", ev_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(logic [5:0] i, logic [5:0] d, logic [5:0] e, logic [2:0] m);
    ev_t x;
    x.inc = i; x.dec = d; x.en = e; x.mode = m;
    ev_q.push_back(x);
  endtask

  task automatic expect_sig(string name, int sel, logic [31:0] exp);
    chk_t x;
    x.name = name; x.sel = sel; x.exp = exp;
    chk_q.push_back(x);
  endtask

  task automatic load(int s, int mi, int h, int d, int mo, int y);
    ld_sec = 6'(s); ld_min = 6'(mi); ld_hour = 5'(h);
    ld_day = 5'(d); ld_month = 4'(mo); ld_year = 7'(y);
    ld = 1'b1; step(); ld = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    done_dec = '0; ld = 1'b0;
    ld_sec = '0; ld_min = '0; ld_hour = '0; ld_day = 5'd1; ld_month = 4'd1; ld_year = '0;
    step(2);
    expect_sig("reset_inc", S_INC, 0);
    expect_sig("reset_dec", S_DEC, 0);
    expect_sig("reset_en", S_EN, 0);
    expect_sig("reset_mode", S_MODE, 0);
    reset = 1'b0;
    step();
    expect_sig("run_en", S_EN, 6'b111111);
    expect_sig("run_mode", S_MODE, 0);
    expect_sig("hour_num", S_HNUM, 23);

    // Single tick
    expect_ev(6'b000001, 6'b0, 6'b111111, 3'd0);
    tick = 1'b1; step(); tick = 1'b0;
    step(12);
    expect_sig("sec_after_tick", S_SEC, 1);

    // Full carry 23:59:59 Jan 31 year 5
    load(59, 59, 23, 31, 1, 5);
    expect_sig("day_num_jan", S_DNUM, 31);
    for (int i = 0; i < 5; i++) expect_ev(6'b000001 << i, 6'b0, 6'b111111, 3'd0);
    tick = 1'b1; step(); tick = 1'b0;
    step(14);
    expect_sig("roll_sec", S_SEC, 0);
    expect_sig("roll_min", S_MIN, 0);
    expect_sig("roll_hour", S_HOUR, 0);
    expect_sig("roll_day", S_DAY, 1);
    expect_sig("roll_month", S_MONTH, 2);
    expect_sig("roll_year", S_YEAR, 5);
    expect_sig("roll_day_num", S_DNUM, 28);

    // Days-in-month table
    load(0, 0, 0, 1, 2, 4);  expect_sig("dnum_feb_leap", S_DNUM, 29);
    load(0, 0, 0, 1, 2, 5);  expect_sig("dnum_feb", S_DNUM, 28);
    load(0, 0, 0, 1, 4, 5);  expect_sig("dnum_apr", S_DNUM, 30);
    load(0, 0, 0, 1, 0, 5);  expect_sig("dnum_month0", S_DNUM, 31);
    load(0, 0, 0, 1, 13, 5); expect_sig("dnum_month13", S_DNUM, 31);

    // SET_MONTH: Jan 31 -> Feb, then clamp day down to 28
    load(0, 0, 0, 31, 1, 1);
    step();
    repeat (5) press_mode();
    expect_sig("set_month_mode", S_MODE, 5);
    expect_sig("set_month_en", S_EN, 6'b010000);
    expect_ev(6'b010000, 6'b0, 6'b010000, 3'd5);
    repeat (3) expect_ev(6'b0, 6'b001000, 6'b011000, 3'd5);
    btn_up = 1'b1; step(); btn_up = 1'b0;
    step(); tick = 1'b1; step(); tick = 1'b0;
    step(10);
    expect_sig("clamp_day", S_DAY, 28);
    expect_sig("clamp_month", S_MONTH, 2);
    expect_sig("clamp_mode", S_MODE, 5);
    expect_sig("clamp_en", S_EN, 6'b010000);
    tick = 1'b1; step(); tick = 1'b0;
    step(3);

    // SET_MIN buttons
    repeat (4) press_mode();
    expect_sig("set_min_mode", S_MODE, 2);
    expect_sig("set_min_en", S_EN, 6'b000010);
    expect_ev(6'b000010, 6'b0, 6'b000010, 3'd2);
    btn_up = 1'b1; step(); btn_up = 1'b0; step(2);
    expect_ev(6'b0, 6'b000010, 6'b000010, 3'd2);
    btn_down = 1'b1; step(); btn_down = 1'b0; step(2);
    btn_up = 1'b1; btn_down = 1'b1; step(); btn_up = 1'b0; btn_down = 1'b0; step(2);
    btn_mode = 1'b1; btn_up = 1'b1; step(); btn_mode = 1'b0; btn_up = 1'b0; step(2);
    expect_sig("mode_wins_mode", S_MODE, 3);
    expect_sig("mode_wins_en", S_EN, 6'b000100);
    expect_sig("set_min_value", S_MIN, 0);
    repeat (4) press_mode();
    expect_sig("back_to_run_mode", S_MODE, 0);
    expect_sig("back_to_run_en", S_EN, 6'b111111);
    done_dec = 5'h1f; step(); done_dec = '0; step(3);

    // Reset in the middle of a carry
    load(59, 0, 0, 1, 2, 1);
    expect_ev(6'b000001, 6'b0, 6'b111111, 3'd0);
    tick = 1'b1; step(); tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_done[0]) break;
      step();
    end
    expect_sig("carry_seen", S_DONE0, 1);
    reset = 1'b1; step();
    expect_sig("midreset_inc", S_INC, 0);
    expect_sig("midreset_en", S_EN, 0);
    expect_sig("midreset_mode", S_MODE, 0);
    step(); reset = 1'b0; step(6);
    expect_sig("carry_lost_min", S_MIN, 0);
    expect_sig("post_reset_mode", S_MODE, 0);
    expect_sig("post_reset_en", S_EN, 6'b111111);
    step(2);
    finishing = 1'b1;
    step(3);
  end

endmodule
